// File: rtl/regs_seq.sv
// regs_seq: two-port access sequencer for the 8x16 user register file.
// Port A (microprogram) has priority; port B (panel/debug) is forced
// through after STARVE_LIMIT consecutive A grants made while B waited.
// Every access runs SETUP -> STROBE (STROBE_CYC cycles) -> HOLD -> ACK.
module regs_seq #(
    parameter int STROBE_CYC   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_sys,
    input  logic        _reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [2:0]  a_sel,
    input  logic [15:0] a_wdata,
    output logic        a_ack,
    output logic [15:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [2:0]  b_sel,
    input  logic [15:0] b_wdata,
    output logic        b_ack,
    output logic [15:0] b_rdata,
    output logic        busy,
    output logic [15:0] w,
    output logic        ra,
    output logic        rb,
    output logic        piszrn,
    output logic        piszrw,
    output logic        czytrn,
    output logic        czytrw,
    input  logic [15:0] l
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        ACK    = 3'd4
    } state_t;

    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);
    localparam logic [3:0] STARVE_MAX  = 4'(STARVE_LIMIT);

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [3:0]  starve, starve_nx;
    logic        grant, grant_b;
    logic        req_we, req_h;
    logic [1:0]  req_adr;
    logic [15:0] req_wdata;
    logic        g_b, g_we, g_h;
    logic        strobe_last;

    assign busy        = (state != IDLE);
    assign strobe_last = (state == STROBE) && (cnt == 4'd0);

    // Arbitration in IDLE: starved B first, then A, then B; maintain starve count.
    always_comb begin
        grant     = 1'b0;
        grant_b   = 1'b0;
        starve_nx = starve;
        if (state == IDLE) begin
            if (b_req && (starve == STARVE_MAX)) begin
                grant     = 1'b1;
                grant_b   = 1'b1;
                starve_nx = 4'd0;
            end else if (a_req) begin
                grant = 1'b1;
                if (b_req)
                    starve_nx = (starve == STARVE_MAX) ? starve : starve + 4'd1;
                else
                    starve_nx = 4'd0;
            end else if (b_req) begin
                grant     = 1'b1;
                grant_b   = 1'b1;
                starve_nx = 4'd0;
            end
        end
    end

    // Request fields of whichever port wins this cycle.
    always_comb begin
        req_we    = grant_b ? b_we : a_we;
        req_h     = grant_b ? b_sel[2] : a_sel[2];
        req_adr   = grant_b ? b_sel[1:0] : a_sel[1:0];
        req_wdata = grant_b ? b_wdata : a_wdata;
    end

    // Next-state logic; cnt counts down the remaining strobe cycles.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE:   if (grant) state_nx = SETUP;
            SETUP: begin
                state_nx = STROBE;
                cnt_nx   = STROBE_LAST;
            end
            STROBE: begin
                if (cnt == 4'd0) state_nx = HOLD;
                else             cnt_nx   = cnt - 4'd1;
            end
            HOLD:   state_nx = ACK;
            ACK:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register, strobe counter and starvation counter.
    always_ff @(posedge clk_sys or negedge _reset) begin
        if (!_reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            starve <= 4'd0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            starve <= starve_nx;
        end
    end

    // Latch the granted port and access type; inputs are ignored afterwards.
    always_ff @(posedge clk_sys or negedge _reset) begin
        if (!_reset) begin
            g_b  <= 1'b0;
            g_we <= 1'b0;
            g_h  <= 1'b0;
        end else if (grant) begin
            g_b  <= grant_b;
            g_we <= req_we;
            g_h  <= req_h;
        end
    end

    // Register-file address/data bus: loaded at grant, stable through ACK.
    always_ff @(posedge clk_sys or negedge _reset) begin
        if (!_reset) begin
            w  <= 16'd0;
            ra <= 1'b0;
            rb <= 1'b0;
        end else if (grant) begin
            w  <= req_we ? req_wdata : 16'd0;
            ra <= req_adr[1];
            rb <= req_adr[0];
        end
    end

    // Strobes and acks registered from next state so they are glitch-free.
    always_ff @(posedge clk_sys or negedge _reset) begin
        if (!_reset) begin
            piszrn <= 1'b0;
            piszrw <= 1'b0;
            czytrn <= 1'b0;
            czytrw <= 1'b0;
            a_ack  <= 1'b0;
            b_ack  <= 1'b0;
        end else begin
            piszrn <= (state_nx == STROBE) &&  g_we && !g_h;
            piszrw <= (state_nx == STROBE) &&  g_we &&  g_h;
            czytrn <= (state_nx == STROBE) && !g_we && !g_h;
            czytrw <= (state_nx == STROBE) && !g_we &&  g_h;
            a_ack  <= (state_nx == ACK) && !g_b;
            b_ack  <= (state_nx == ACK) &&  g_b;
        end
    end

    // Read data captured from l on the final strobe cycle of a read.
    always_ff @(posedge clk_sys or negedge _reset) begin
        if (!_reset) begin
            a_rdata <= 16'd0;
            b_rdata <= 16'd0;
        end else if (strobe_last && !g_we) begin
            if (g_b) b_rdata <= l;
            else     a_rdata <= l;
        end
    end

    // At most one register-file strobe may be active in any cycle.
    a_strobe_onehot: assert property (@(posedge clk_sys) disable iff (!_reset)
        $onehot0({piszrn, piszrw, czytrn, czytrw}));

endmodule

// File: tb/tb_regs_seq.sv
// tb_regs_seq: three builds (STROBE_CYC = 2, 1, 15) driven in parallel,
// checked every cycle against a transaction-timeline model plus literals.
module tb_regs_seq;
    localparam int NG  = 3;
    localparam int LIM = 4;

    logic clk_sys = 1'b0;
    logic rst_n;
    always #5 clk_sys = ~clk_sys;

    logic        a_req [NG], a_we [NG], a_ack [NG];
    logic [2:0]  a_sel [NG];
    logic [15:0] a_wdata [NG], a_rdata [NG];
    logic        b_req [NG], b_we [NG], b_ack [NG];
    logic [2:0]  b_sel [NG];
    logic [15:0] b_wdata [NG], b_rdata [NG];
    logic        busy [NG], ra [NG], rb [NG];
    logic        piszrn [NG], piszrw [NG], czytrn [NG], czytrw [NG];
    logic [15:0] w [NG], l [NG];

    logic [15:0] rf_mem [NG][8] = '{default: '0};
    logic [15:0] noise [NG]     = '{default: '0};

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    function automatic int sc_of(input int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : 15;
    endfunction
    // Hand-computed per-build expectations.
    function automatic int lit_lat(input int g);
        return (g == 0) ? 5 : (g == 1) ? 4 : 18;
    endfunction
    function automatic int lit_sc(input int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : 15;
    endfunction
    function automatic int lit_b2(input int g);
        return (g == 0) ? 11 : (g == 1) ? 9 : 37;
    endfunction

    task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t got=%h expected=%h", nm, g, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < NG; g++) begin : gd
        localparam int SC = (g == 0) ? 2 : (g == 1) ? 1 : 15;
        regs_seq #(.STROBE_CYC(SC), .STARVE_LIMIT(LIM)) dut (
            .clk_sys(clk_sys), ._reset(rst_n),
            .a_req(a_req[g]), .a_we(a_we[g]), .a_sel(a_sel[g]), .a_wdata(a_wdata[g]),
            .a_ack(a_ack[g]), .a_rdata(a_rdata[g]),
            .b_req(b_req[g]), .b_we(b_we[g]), .b_sel(b_sel[g]), .b_wdata(b_wdata[g]),
            .b_ack(b_ack[g]), .b_rdata(b_rdata[g]),
            .busy(busy[g]), .w(w[g]), .ra(ra[g]), .rb(rb[g]),
            .piszrn(piszrn[g]), .piszrw(piszrw[g]), .czytrn(czytrn[g]), .czytrw(czytrw[g]),
            .l(l[g])
        );
        // Register file: returns data only while a read strobe is high.
        assign l[g] = czytrn[g] ? rf_mem[g][{1'b0, ra[g], rb[g]}] :
                      czytrw[g] ? rf_mem[g][{1'b1, ra[g], rb[g]}] : noise[g];
    end

    always @(posedge clk_sys)
        for (int g = 0; g < NG; g++) begin
            if (piszrn[g]) rf_mem[g][{1'b0, ra[g], rb[g]}] <= w[g];
            if (piszrw[g]) rf_mem[g][{1'b1, ra[g], rb[g]}] <= w[g];
        end

    always @(negedge clk_sys)
        for (int g = 0; g < NG; g++) noise[g] <= 16'($urandom);

    // Reference model: t = cycles since the grant edge of the active access.
    bit          m_act [NG], m_b [NG], m_we [NG], m_ra [NG], m_rb [NG];
    int          m_t [NG], m_starve [NG];
    logic [2:0]  m_sel [NG];
    logic [15:0] m_wd [NG], m_w [NG], m_ard [NG], m_brd [NG];
    logic [15:0] m_rf [NG][8] = '{default: '0};

    always @(posedge clk_sys or negedge rst_n)
        for (int g = 0; g < NG; g++) begin
            if (!rst_n) begin
                m_act[g] = 0; m_t[g] = 0; m_starve[g] = 0; m_b[g] = 0; m_we[g] = 0;
                m_ard[g] = '0; m_brd[g] = '0; m_w[g] = '0; m_ra[g] = 0; m_rb[g] = 0;
            end else if (m_act[g]) begin
                m_t[g]++;
                if (m_t[g] == sc_of(g) + 2) begin
                    if (m_we[g])     m_rf[g][m_sel[g]] = m_wd[g];
                    else if (m_b[g]) m_brd[g] = m_rf[g][m_sel[g]];
                    else             m_ard[g] = m_rf[g][m_sel[g]];
                end
                if (m_t[g] > sc_of(g) + 3) m_act[g] = 0;
            end else if (a_req[g] || b_req[g]) begin
                m_b[g] = b_req[g] && (m_starve[g] == LIM || !a_req[g]);
                if (m_b[g])        m_starve[g] = 0;
                else if (b_req[g]) m_starve[g] = (m_starve[g] < LIM) ? m_starve[g] + 1 : LIM;
                else               m_starve[g] = 0;
                m_we[g]  = m_b[g] ? b_we[g]    : a_we[g];
                m_sel[g] = m_b[g] ? b_sel[g]   : a_sel[g];
                m_wd[g]  = m_b[g] ? b_wdata[g] : a_wdata[g];
                m_act[g] = 1; m_t[g] = 1;
                m_w[g]  = m_we[g] ? m_wd[g] : 16'h0;
                m_ra[g] = m_sel[g][1]; m_rb[g] = m_sel[g][0];
            end
        end

    // Compare every DUT output against the model each cycle.
    always @(negedge clk_sys)
        if (chk_en)
            for (int g = 0; g < NG; g++) begin
                logic [56:0] ev, av;
                bit stb, ak;
                stb = m_act[g] && m_t[g] >= 2 && m_t[g] <= sc_of(g) + 1;
                ak  = m_act[g] && m_t[g] == sc_of(g) + 3;
                ev = {m_act[g], ak && !m_b[g], ak && m_b[g],
                      stb && m_we[g] && !m_sel[g][2], stb && m_we[g] && m_sel[g][2],
                      stb && !m_we[g] && !m_sel[g][2], stb && !m_we[g] && m_sel[g][2],
                      m_ra[g], m_rb[g], m_w[g], m_ard[g], m_brd[g]};
                av = {busy[g], a_ack[g], b_ack[g], piszrn[g], piszrw[g], czytrn[g], czytrw[g],
                      ra[g], rb[g], w[g], a_rdata[g], b_rdata[g]};
                chk("cycle_cmp", g, 64'(av), 64'(ev));
            end

    int          lat [NG], c_pn [NG], c_pw [NG], c_rn [NG], c_rw [NG];
    logic [15:0] rd_ack [NG], w_ack [NG];
    logic        ra_ack [NG], rb_ack [NG];

    // One access on every build at once; records latency and strobe widths.
    task automatic txn(input bit pb, input bit we, input logic [2:0] sel, input logic [15:0] wd);
        bit done [NG];
        bit all;
        int cyc;
        @(negedge clk_sys);
        for (int g = 0; g < NG; g++) begin
            done[g] = 0; lat[g] = -1; c_pn[g] = 0; c_pw[g] = 0; c_rn[g] = 0; c_rw[g] = 0;
            if (pb) begin b_req[g] = 1; b_we[g] = we; b_sel[g] = sel; b_wdata[g] = wd; end
            else    begin a_req[g] = 1; a_we[g] = we; a_sel[g] = sel; a_wdata[g] = wd; end
        end
        cyc = 0; all = 0;
        while (!all && cyc < 60) begin
            @(negedge clk_sys);
            cyc++; all = 1;
            for (int g = 0; g < NG; g++)
                if (!done[g]) begin
                    c_pn[g] += int'(piszrn[g]); c_pw[g] += int'(piszrw[g]);
                    c_rn[g] += int'(czytrn[g]); c_rw[g] += int'(czytrw[g]);
                    if (pb ? b_ack[g] : a_ack[g]) begin
                        lat[g] = cyc; done[g] = 1;
                        rd_ack[g] = pb ? b_rdata[g] : a_rdata[g];
                        w_ack[g] = w[g]; ra_ack[g] = ra[g]; rb_ack[g] = rb[g];
                        if (pb) b_req[g] = 0; else a_req[g] = 0;
                    end else all = 0;
                end
        end
        for (int g = 0; g < NG; g++) begin a_req[g] = 0; b_req[g] = 0; end
    endtask

    task automatic rnd_drive(input int g);
        if (a_req[g] && a_ack[g]) begin
            a_req[g] = ($urandom_range(0, 2) == 0);
            a_we[g] = 1'($urandom); a_sel[g] = 3'($urandom); a_wdata[g] = 16'($urandom);
        end else if (a_req[g]) begin
            if ($urandom_range(0, 19) == 0) a_req[g] = 0;
            if ($urandom_range(0, 7) == 0) a_wdata[g] = 16'($urandom);
        end else if ($urandom_range(0, 2) == 0) begin
            a_req[g] = 1; a_we[g] = 1'($urandom); a_sel[g] = 3'($urandom); a_wdata[g] = 16'($urandom);
        end
        if (b_req[g] && b_ack[g]) begin
            b_req[g] = ($urandom_range(0, 2) == 0);
            b_we[g] = 1'($urandom); b_sel[g] = 3'($urandom); b_wdata[g] = 16'($urandom);
        end else if (b_req[g]) begin
            if ($urandom_range(0, 29) == 0) b_req[g] = 0;
            if ($urandom_range(0, 7) == 0) b_sel[g] = 3'($urandom);
        end else if ($urandom_range(0, 3) == 0) begin
            b_req[g] = 1; b_we[g] = 1'($urandom); b_sel[g] = 3'($urandom); b_wdata[g] = 16'($urandom);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a_at [NG], b_at [NG], nack [NG];
        logic [9:0] seq [NG];
        bit all;
        int cyc;
        rst_n = 1'b0;
        for (int g = 0; g < NG; g++) begin
            a_req[g] = 0; a_we[g] = 0; a_sel[g] = '0; a_wdata[g] = '0;
            b_req[g] = 0; b_we[g] = 0; b_sel[g] = '0; b_wdata[g] = '0;
        end
        repeat (3) @(negedge clk_sys);
        for (int g = 0; g < NG; g++) begin
            chk("rst_busy", g, 64'(busy[g]), 64'd0);
            chk("rst_bus", g, 64'({w[g], ra[g], rb[g]}), 64'd0);
            chk("rst_strobes", g, 64'({piszrn[g], piszrw[g], czytrn[g], czytrw[g], a_ack[g], b_ack[g]}), 64'd0);
            chk("rst_rdata", g, 64'({a_rdata[g], b_rdata[g]}), 64'd0);
        end
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Write/read round trip on the h=1 bank.
        txn(0, 1, 3'b101, 16'hBEEF);
        for (int g = 0; g < NG; g++) begin
            chk("wr_lat", g, 64'(lat[g]), 64'(lit_lat(g)));
            chk("wr_piszrw_width", g, 64'(c_pw[g]), 64'(lit_sc(g)));
            chk("wr_other_strobes", g, 64'(c_pn[g] + c_rn[g] + c_rw[g]), 64'd0);
            chk("wr_bus", g, 64'({w_ack[g], ra_ack[g], rb_ack[g]}), 64'({16'hBEEF, 1'b0, 1'b1}));
        end
        txn(0, 0, 3'b101, 16'h0);
        for (int g = 0; g < NG; g++) begin
            chk("rd_lat", g, 64'(lat[g]), 64'(lit_lat(g)));
            chk("rd_czytrw_width", g, 64'(c_rw[g]), 64'(lit_sc(g)));
            chk("rd_data", g, 64'(rd_ack[g]), 64'h BEEF);
        end

        // Bank separation n/w.
        txn(0, 1, 3'b010, 16'h1111);
        for (int g = 0; g < NG; g++)
            chk("bank_n_strobes", g, 64'({8'(c_pn[g]), 8'(c_pw[g])}), 64'({8'(lit_sc(g)), 8'd0}));
        txn(0, 1, 3'b110, 16'h2222);
        for (int g = 0; g < NG; g++)
            chk("bank_w_strobes", g, 64'({8'(c_pn[g]), 8'(c_pw[g])}), 64'({8'd0, 8'(lit_sc(g))}));
        txn(1, 0, 3'b010, 16'h0);
        for (int g = 0; g < NG; g++) begin
            chk("bank_n_czytrn", g, 64'(c_rn[g]), 64'(lit_sc(g)));
            chk("bank_n_rdata", g, 64'(rd_ack[g]), 64'h1111);
        end
        txn(0, 0, 3'b110, 16'h0);
        for (int g = 0; g < NG; g++) begin
            chk("bank_w_czytrw", g, 64'(c_rw[g]), 64'(lit_sc(g)));
            chk("bank_w_rdata", g, 64'(rd_ack[g]), 64'h2222);
        end

        // Simultaneous single requests: A first, B after the following IDLE cycle.
        @(negedge clk_sys);
        for (int g = 0; g < NG; g++) begin
            a_at[g] = -1; b_at[g] = -1;
            a_req[g] = 1; a_we[g] = 1; a_sel[g] = 3'b000; a_wdata[g] = 16'h0A0A;
            b_req[g] = 1; b_we[g] = 1; b_sel[g] = 3'b111; b_wdata[g] = 16'h0B0B;
        end
        cyc = 0; all = 0;
        while (!all && cyc < 80) begin
            @(negedge clk_sys);
            cyc++; all = 1;
            for (int g = 0; g < NG; g++) begin
                if (a_ack[g] && a_at[g] < 0) begin a_at[g] = cyc; a_req[g] = 0; end
                if (b_ack[g] && b_at[g] < 0) begin b_at[g] = cyc; b_req[g] = 0; end
                if (b_at[g] < 0) all = 0;
            end
        end
        for (int g = 0; g < NG; g++) begin
            a_req[g] = 0; b_req[g] = 0;
            chk("simul_a_ack", g, 64'(a_at[g]), 64'(lit_lat(g)));
            chk("simul_b_ack", g, 64'(b_at[g]), 64'(lit_b2(g)));
        end

        // Starvation: both held continuously -> A,A,A,A,B,A,A,A,A,B.
        @(negedge clk_sys);
        for (int g = 0; g < NG; g++) begin
            nack[g] = 0; seq[g] = '0;
            a_req[g] = 1; a_we[g] = 0; a_sel[g] = 3'b001;
            b_req[g] = 1; b_we[g] = 0; b_sel[g] = 3'b110;
        end
        cyc = 0; all = 0;
        while (!all && cyc < 500) begin
            @(negedge clk_sys);
            cyc++; all = 1;
            for (int g = 0; g < NG; g++) begin
                if (nack[g] < 10 && (a_ack[g] || b_ack[g])) begin
                    seq[g] = {seq[g][8:0], b_ack[g]};
                    nack[g]++;
                    if (nack[g] == 10) begin a_req[g] = 0; b_req[g] = 0; end
                end
                if (nack[g] < 10) all = 0;
            end
        end
        for (int g = 0; g < NG; g++) begin
            a_req[g] = 0; b_req[g] = 0;
            chk("starve_seq", g, 64'(seq[g]), 64'(10'b0000100001));
        end
        repeat (2) @(negedge clk_sys);

        // Reset during the first strobe cycle of a write.
        for (int g = 0; g < NG; g++) begin
            a_req[g] = 1; a_we[g] = 1; a_sel[g] = 3'b011; a_wdata[g] = 16'hA5A5;
        end
        repeat (2) @(negedge clk_sys);
        for (int g = 0; g < NG; g++) chk("pre_rst_strobe", g, 64'(piszrn[g]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < NG; g++) begin
            chk("async_rst_strobes", g, 64'({piszrn[g], piszrw[g], czytrn[g], czytrw[g]}), 64'd0);
            chk("async_rst_busy", g, 64'(busy[g]), 64'd0);
            a_req[g] = 0;
        end
        repeat (2) @(negedge clk_sys);
        rst_n = 1'b1;
        txn(0, 1, 3'b100, 16'h5A5A);
        for (int g = 0; g < NG; g++) chk("post_rst_lat", g, 64'(lat[g]), 64'(lit_lat(g)));
        txn(1, 0, 3'b100, 16'h0);
        for (int g = 0; g < NG; g++) chk("post_rst_rdata", g, 64'(rd_ack[g]), 64'h5A5A);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk_sys);
            for (int g = 0; g < NG; g++) rnd_drive(g);
        end
        for (int g = 0; g < NG; g++) begin a_req[g] = 0; b_req[g] = 0; end
        cyc = 0; all = 0;
        while (!all && cyc < 40) begin
            @(negedge clk_sys);
            cyc++; all = 1;
            for (int g = 0; g < NG; g++) if (busy[g]) all = 0;
        end
        for (int g = 0; g < NG; g++) chk("drain_idle", g, 64'(busy[g]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regs_seq.md
Name: regs_seq

Overview:
- Access sequencer and arbiter for the 8x16 user register file.
- Shares the register file between two requesters:
  - port A: microprogram control, high priority.
  - port B: front panel / debug, low priority, starvation-protected.
- Converts each single-cycle-synchronous request into a timed register-file cycle: address/data setup, then strobe pulse with read capture, then hold, then ack.

Parameters:
STROBE_CYC, 2, cycles the strobe stays high (legal 1..15)
STARVE_LIMIT, 4, consecutive port-A grants while B waits before B is forced through (legal 1..15)

Ports:
clk_sys  in  1  system clock, all state on rising edge
_reset  in  1  asynchronous active-low reset
a_req  in  1  port A request, held until a_ack
a_we  in  1  port A: 1=write, 0=read
a_sel  in  3  port A register select {h,ra,rb}
a_wdata  in  16  port A write data
a_ack  out  1  port A one-cycle completion pulse
a_rdata  out  16  port A read data, valid when a_ack=1, held until next A read
b_req, b_we, b_sel, b_wdata, b_ack, b_rdata  same as port A, for port B
busy  out  1  high in every state except IDLE
w  out  16  data to register file
ra, rb  out  1  register address bits
piszrn, piszrw  out  1  write strobes, h=0 / h=1
czytrn, czytrw  out  1  read strobes, h=0 / h=1
l  in  16  register file read data, valid only while a read strobe is high

Behaviour:
- Reset (asynchronous, _reset=0):
  - state=IDLE, all strobes=0, w=0, ra=rb=0.
  - a_ack=b_ack=0, a_rdata=b_rdata=0, busy=0, starve counter=0.
  - Reset mid-transaction: strobes drop immediately, no ack, transaction lost.
- FSM: IDLE -> SETUP -> STROBE -> HOLD -> ACK -> IDLE.
  - IDLE:
    - Samples a_req/b_req.
    - Grant rule: if B pending and starve==STARVE_LIMIT, grant B; else A if pending; else B if pending; else stay IDLE.
    - Grant latches we, sel, wdata and the granted port into internal registers. Later changes on request inputs have no effect on the current transaction.
  - SETUP, 1 cycle:
    - Drive w (write data for writes, 0 for reads), ra=sel[1], rb=sel[0].
    - No strobe.
  - STROBE, STROBE_CYC cycles:
    - Exactly one strobe high, chosen by we and sel[2]:
      - write, h=0: piszrn
      - write, h=1: piszrw
      - read, h=0: czytrn
      - read, h=1: czytrw
    - w, ra and rb stay stable.
    - Reads capture l into the granted port's rdata on the last STROBE cycle.
  - HOLD, 1 cycle: strobes=0; w, ra and rb remain stable.
  - ACK, 1 cycle: granted port's ack=1; w, ra and rb remain stable.
  - Then IDLE.
- Latency:
  - Request sampled in IDLE at edge 0: SETUP at 1, STROBE at 2..STROBE_CYC+1, HOLD at STROBE_CYC+2, ack at STROBE_CYC+3.
  - Default: ack 5 cycles after grant; 6-cycle transaction including the IDLE cycle.
- Back-to-back: at least one IDLE cycle between transactions. A requester still asserting req in the cycle after its ack is treated as a new request.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, on each A grant made while b_req=1.
  - Clears on any B grant.
  - Clears on any A grant made while b_req=0.
- Simultaneous a_req and b_req: A wins unless starve==STARVE_LIMIT.
- req deasserted before ack: transaction still completes and ack still pulses.
- rdata is unchanged by writes and by the other port's transactions.
- Strobes are glitch-free: registered outputs, at most one high at any time.

Test Plan:
- Write/read round trip: A write sel=3'b101, wdata=16'hBEEF, then A read sel=3'b101.
  - Write: piszrw high for 2 cycles with ra=0, rb=1, w=16'hBEEF; a_ack 5 cycles after grant.
  - Read: czytrw high for 2 cycles; a_rdata=16'hBEEF at a_ack.
- n/w bank separation: write 16'h1111 to sel=3'b010 and 16'h2222 to sel=3'b110.
  - Only piszrn strobes for the first, only piszrw for the second.
  - Read-back returns 16'h1111 and 16'h2222 respectively.
- Starvation: a_req and b_req held continuously with STARVE_LIMIT=4 -> grant sequence A,A,A,A,B,A,A,A,A,B; b_ack each fifth transaction.
- Simultaneous single requests: a_req and b_req rise in the same cycle, starve=0 -> A served first, B granted after the IDLE cycle following a_ack.
- Reset mid-strobe: _reset low during the first STROBE cycle of a write.
  - Strobes and busy go to 0 without waiting for a clock edge; no ack.
  - After release, state=IDLE and a new request completes normally.
- STROBE_CYC=1 and STROBE_CYC=15 builds: strobe width exactly 1 and 15 cycles; ack at grant+4 and grant+18; read data captured correctly in both builds.
